// File: rtl/acq_sched_pkg.sv
// Shared types and constants for the acquisition scheduler: FSM states,
// lane/group geometry and the group-to-base-PRN mapping.
package acq_sched_pkg;

  localparam int LANES  = 4;
  localparam int GROUPS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_REPORT,
    ST_NEXT,
    ST_DONE
  } state_t;

  function automatic logic [5:0] base_prn(input logic [2:0] g);
    return {1'b0, g, 2'b00} + 6'd1;
  endfunction

endpackage

// File: rtl/acq_peak_tracker.sv
// One correlator lane: keeps the strictly-greatest metric seen since the last
// clear, together with the code phase and Doppler where it occurred.
module acq_peak_tracker #(
  parameter int METRIC_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                sample,
  input  logic [METRIC_W-1:0] metric,
  input  logic [9:0]          phase,
  input  logic signed [15:0]  doppler,
  output logic [METRIC_W-1:0] peak,
  output logic [9:0]          peak_phase,
  output logic signed [15:0]  peak_doppler
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak         <= '0;
      peak_phase   <= '0;
      peak_doppler <= '0;
    end else if (clear) begin
      peak         <= '0;
      peak_phase   <= '0;
      peak_doppler <= '0;
    end else if (sample && (metric > peak)) begin
      // strictly greater: the earliest of several equal peaks is retained
      peak         <= metric;
      peak_phase   <= phase;
      peak_doppler <= doppler;
    end
  end

endmodule

// File: rtl/acq_sched.sv
// Acquisition scheduler: walks the enabled 4-PRN groups through the correlator
// core and reports each lane's peak. Optional watchdog: ACQ_SCHED_TIMEOUT_EN.
module acq_sched
  import acq_sched_pkg::*;
#(
  parameter int                  METRIC_W       = 12,
  parameter logic [METRIC_W-1:0] THRESHOLD      = 12'd2400,
  parameter logic [23:0]         TIMEOUT_CYCLES = 24'd16000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         sat_mask,
  output logic                core_start,
  output logic [5:0]          core_sat_base,
  input  logic                core_corr_valid,
  input  logic [9:0]          core_code_phase,
  input  logic signed [15:0]  core_doppler,
  input  logic [METRIC_W-1:0] core_metric0,
  input  logic [METRIC_W-1:0] core_metric1,
  input  logic [METRIC_W-1:0] core_metric2,
  input  logic [METRIC_W-1:0] core_metric3,
  input  logic                core_group_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [5:0]          res_prn,
  output logic [9:0]          res_code_phase,
  output logic signed [15:0]  res_doppler,
  output logic [METRIC_W-1:0] res_metric,
  output logic                res_found,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  state_t              state;
  logic [31:0]         mask_q;
  logic [2:0]          group;
  logic [1:0]          lane;
  logic [3:0]          grp_mask;
  logic [3:0]          first_grp;
  logic [3:0]          succ_grp;
  logic [2:0]          first_lane;
  logic [2:0]          succ_lane;
  logic [1:0]          ld_lane;
  logic                accept;
  logic                tmo_hit;

  logic [METRIC_W-1:0] metric_in    [LANES];
  logic [METRIC_W-1:0] peak         [LANES];
  logic [9:0]          peak_phase   [LANES];
  logic signed [15:0]  peak_doppler [LANES];

  // {found, index} of the lowest group at or above 'from' with any enabled lane
  function automatic logic [3:0] next_group(input logic [31:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int g = GROUPS - 1; g >= 0; g--) begin
      if ((g >= int'(from)) && (|m[4*g +: 4])) r = {1'b1, 3'(g)};
    end
    return r;
  endfunction

  function automatic logic [2:0] next_lane(input logic [3:0] lm, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if ((k >= int'(from)) && lm[k]) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  assign metric_in[0] = core_metric0;
  assign metric_in[1] = core_metric1;
  assign metric_in[2] = core_metric2;
  assign metric_in[3] = core_metric3;

  assign grp_mask   = mask_q[{group, 2'b00} +: 4];
  assign first_grp  = next_group(sat_mask, 4'd0);
  assign succ_grp   = next_group(mask_q, {1'b0, group} + 4'd1);
  assign first_lane = next_lane(grp_mask, 3'd0);
  assign succ_lane  = next_lane(grp_mask, {1'b0, lane} + 3'd1);
  assign ld_lane    = res_valid ? succ_lane[1:0] : lane;
  assign accept     = (state == ST_IDLE) && start && !abort;
  assign busy       = (state != ST_IDLE);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acq_peak_tracker #(.METRIC_W(METRIC_W)) u_trk (
      .clk          (clk),
      .rst          (rst),
      .clear        (state == ST_LAUNCH),
      .sample       ((state == ST_WAIT) && core_corr_valid),
      .metric       (metric_in[k]),
      .phase        (core_code_phase),
      .doppler      (core_doppler),
      .peak         (peak[k]),
      .peak_phase   (peak_phase[k]),
      .peak_doppler (peak_doppler[k])
    );
  end

`ifdef ACQ_SCHED_TIMEOUT_EN
  logic [23:0] tcount;

  assign tmo_hit = (state == ST_WAIT) && (tcount == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcount      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_LAUNCH)    tcount <= '0;
      else if (state == ST_WAIT) tcount <= tcount + 24'd1;
      if (accept) timeout_err <= 1'b0;
      else if (tmo_hit && !core_group_done && !abort) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      mask_q         <= '0;
      group          <= '0;
      lane           <= '0;
      core_start     <= 1'b0;
      core_sat_base  <= 6'd1;
      done           <= 1'b0;
      res_valid      <= 1'b0;
      res_prn        <= '0;
      res_code_phase <= '0;
      res_doppler    <= '0;
      res_metric     <= '0;
      res_found      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state     <= ST_IDLE;
        res_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              mask_q <= sat_mask;
              if (first_grp[3]) begin
                group         <= first_grp[2:0];
                core_sat_base <= base_prn(first_grp[2:0]);
                core_start    <= 1'b1;
                state         <= ST_LAUNCH;
              end else begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_LAUNCH: state <= ST_WAIT;
          ST_WAIT: begin
            if (core_group_done || tmo_hit) begin
              lane  <= first_lane[1:0];
              state <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            // first cycle loads the lane; later loads happen on each transfer
            if (!res_valid || (res_ready && succ_lane[2])) begin
              lane           <= ld_lane;
              res_valid      <= 1'b1;
              res_prn        <= core_sat_base + {4'b0, ld_lane};
              res_code_phase <= peak_phase[ld_lane];
              res_doppler    <= peak_doppler[ld_lane];
              res_metric     <= peak[ld_lane];
              res_found      <= (peak[ld_lane] >= THRESHOLD);
            end else if (res_ready) begin
              res_valid <= 1'b0;
              state     <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (succ_grp[3]) begin
              group         <= succ_grp[2:0];
              core_sat_base <= base_prn(succ_grp[2:0]);
              core_start    <= 1'b1;
              state         <= ST_LAUNCH;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_sched.sv
// Directed bench for acq_sched: group walking, peak selection, back-pressure,
// abort and (with ACQ_SCHED_TIMEOUT_EN) the per-group watchdog.
module tb_acq_sched;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, abort;
  logic [31:0]        sat_mask;
  logic               core_start;
  logic [5:0]         core_sat_base;
  logic               core_corr_valid;
  logic [9:0]         core_code_phase;
  logic signed [15:0] core_doppler;
  logic [11:0]        core_metric0, core_metric1, core_metric2, core_metric3;
  logic               core_group_done;
  logic               res_valid, res_ready;
  logic [5:0]         res_prn;
  logic [9:0]         res_code_phase;
  logic signed [15:0] res_doppler;
  logic [11:0]        res_metric;
  logic               res_found;
  logic               busy, done, timeout_err;

  typedef struct {
    logic [5:0]         prn;
    logic [9:0]         ph;
    logic signed [15:0] dop;
    logic [11:0]        met;
    logic               found;
  } res_t;

  res_t       res_q[$];
  logic [5:0] base_q[$];
  int         n_done = 0;
  int         n_launch = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  acq_sched #(.METRIC_W(12), .THRESHOLD(12'd2400), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sat_mask(sat_mask),
    .core_start(core_start), .core_sat_base(core_sat_base),
    .core_corr_valid(core_corr_valid), .core_code_phase(core_code_phase),
    .core_doppler(core_doppler), .core_metric0(core_metric0),
    .core_metric1(core_metric1), .core_metric2(core_metric2),
    .core_metric3(core_metric3), .core_group_done(core_group_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_prn(res_prn),
    .res_code_phase(res_code_phase), .res_doppler(res_doppler),
    .res_metric(res_metric), .res_found(res_found), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  // Inputs change 1 time unit after posedge; this snapshot sees what the next edge commits.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready)
        res_q.push_back('{res_prn, res_code_phase, res_doppler, res_metric, res_found});
      if (core_start) begin
        n_launch++;
        base_q.push_back(core_sat_base);
      end
      if (done) n_done++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_search(input logic [31:0] m);
    sat_mask = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // returns with the FSM in WAIT
  task automatic wait_launch(input string tag);
    int n = 0;
    while (!core_start && n < 40) begin
      tick();
      n++;
    end
    check_val(tag, core_start, 1);
    tick();
  endtask

  task automatic feed(input int m0, input int m1, input int m2, input int m3,
                      input int ph, input int dop, input logic gd);
    core_metric0    = 12'(m0);
    core_metric1    = 12'(m1);
    core_metric2    = 12'(m2);
    core_metric3    = 12'(m3);
    core_code_phase = 10'(ph);
    core_doppler    = 16'(dop);
    core_corr_valid = 1'b1;
    core_group_done = gd;
    tick();
    core_corr_valid = 1'b0;
    core_group_done = 1'b0;
  endtask

  task automatic group_done_pulse();
    core_group_done = 1'b1;
    tick();
    core_group_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check_val(tag, busy, 0);
  endtask

  task automatic check_res(input int idx, input string tag, input int prn, input int ph,
                           input int dop, input int met, input int found);
    if (idx < res_q.size()) begin
      check_val({tag, ".prn"},   res_q[idx].prn, prn);
      check_val({tag, ".phase"}, res_q[idx].ph, ph);
      check_val({tag, ".dop"},   res_q[idx].dop, dop);
      check_val({tag, ".met"},   res_q[idx].met, met);
      check_val({tag, ".found"}, res_q[idx].found, found);
    end else begin
      check_val({tag, ".present"}, res_q.size(), idx + 1);
    end
  endtask

  initial begin
    int r0, d0, l0, n, chg;
    logic [5:0] s_prn;
    logic [9:0] s_ph;
    logic [11:0] s_met;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sat_mask = '0;
    core_corr_valid = 1'b0; core_group_done = 1'b0; core_code_phase = '0;
    core_doppler = '0; core_metric0 = '0; core_metric1 = '0; core_metric2 = '0;
    core_metric3 = '0; res_ready = 1'b1;
    repeat (3) tick();
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.core_start", core_start, 0);
    check_val("rst.res_valid", res_valid, 0);
    check_val("rst.timeout_err", timeout_err, 0);
    check_val("rst.base", core_sat_base, 1);
    rst = 1'b0;
    tick();

    // single group, peak on lane 2
    r0 = res_q.size(); d0 = n_done; l0 = n_launch;
    start_search(32'h0000000F);
    wait_launch("t1.launch");
    feed(1000, 1100, 1200,  500, 100, -5, 1'b0);
    feed( 900, 1000, 3000,  400, 517, 26, 1'b0);
    feed(1500,  800, 2999, 2500, 600, 30, 1'b0);
    group_done_pulse();
    wait_idle("t1.idle");
    check_val("t1.nres", res_q.size() - r0, 4);
    check_val("t1.nlaunch", n_launch - l0, 1);
    check_val("t1.base", base_q[l0], 1);
    check_val("t1.ndone", n_done - d0, 1);
    check_res(r0 + 0, "t1.prn1", 1, 600, 30, 1500, 0);
    check_res(r0 + 1, "t1.prn2", 2, 100, -5, 1100, 0);
    check_res(r0 + 2, "t1.prn3", 3, 517, 26, 3000, 1);
    check_res(r0 + 3, "t1.prn4", 4, 600, 30, 2500, 1);

    // first and last group; corr_valid coinciding with group_done is counted
    r0 = res_q.size(); d0 = n_done; l0 = n_launch;
    start_search(32'h80000001);
    wait_launch("t2.launch0");
    feed(2000, 9, 9, 9, 5, 7, 1'b0);
    group_done_pulse();
    wait_launch("t2.launch7");
    feed(1, 1, 1, 2600, 900, -100, 1'b0);
    feed(1, 1, 1, 2700, 901, -101, 1'b1);
    wait_idle("t2.idle");
    check_val("t2.nlaunch", n_launch - l0, 2);
    if (n_launch - l0 == 2) begin
      check_val("t2.base0", base_q[l0], 1);
      check_val("t2.base1", base_q[l0 + 1], 29);
    end
    check_val("t2.nres", res_q.size() - r0, 2);
    check_res(r0 + 0, "t2.prn1", 1, 5, 7, 2000, 0);
    check_res(r0 + 1, "t2.prn32", 32, 901, -101, 2700, 1);
    check_val("t2.ndone", n_done - d0, 1);

    // equal peaks keep the first; just below threshold is not found
    r0 = res_q.size();
    start_search(32'h00000003);
    wait_launch("t3.launch");
    feed(2399, 2500, 0, 0, 10, 0, 1'b0);
    feed( 100, 2500, 0, 0, 20, 0, 1'b0);
    group_done_pulse();
    wait_idle("t3.idle");
    check_val("t3.nres", res_q.size() - r0, 2);
    check_res(r0 + 0, "t3.prn1", 1, 10, 0, 2399, 0);
    check_res(r0 + 1, "t3.prn2", 2, 10, 0, 2500, 1);

    // back-pressure: fields hold for 50 cycles; a start while busy is ignored
    r0 = res_q.size();
    res_ready = 1'b0;
    start_search(32'h0000000F);
    wait_launch("t4.launch");
    feed(10, 20, 30, 40, 3, 1, 1'b0);
    group_done_pulse();
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    check_val("t4.valid", res_valid, 1);
    s_prn = res_prn; s_ph = res_code_phase; s_met = res_metric;
    chg = 0;
    sat_mask = 32'h0; start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      start = 1'b0;
      if (!res_valid || res_prn !== s_prn || res_code_phase !== s_ph || res_metric !== s_met)
        chg++;
    end
    check_val("t4.hold_stable", chg, 0);
    check_val("t4.hold_prn", s_prn, 1);
    check_val("t4.no_xfer", res_q.size() - r0, 0);
    res_ready = 1'b1;
    wait_idle("t4.idle");
    check_val("t4.nres", res_q.size() - r0, 4);
    for (int i = 0; i < 4; i++) check_res(r0 + i, "t4.res", i + 1, 3, 1, 10 * (i + 1), 0);

    // abort in WAIT with simultaneous group_done, then rerun same mask
    r0 = res_q.size(); d0 = n_done;
    start_search(32'h00000001);
    wait_launch("t5.launch");
    feed(2600, 0, 0, 0, 1, 0, 1'b0);
    abort = 1'b1; core_group_done = 1'b1;
    tick();
    abort = 1'b0; core_group_done = 1'b0;
    check_val("t5.busy_after_abort", busy, 0);
    repeat (5) tick();
    check_val("t5.res_valid", res_valid, 0);
    check_val("t5.nres", res_q.size() - r0, 0);
    check_val("t5.ndone", n_done - d0, 0);
    start_search(32'h00000001);
    wait_launch("t5.relaunch");
    feed(2600, 0, 0, 0, 44, 0, 1'b0);
    group_done_pulse();
    wait_idle("t5.idle");
    check_val("t5.nres2", res_q.size() - r0, 1);
    check_res(r0, "t5.prn1", 1, 44, 0, 2600, 1);
    check_val("t5.ndone2", n_done - d0, 1);

    // empty mask: straight to DONE
    r0 = res_q.size(); l0 = n_launch;
    start_search(32'h0);
    check_val("t6.done", done, 1);
    check_val("t6.busy", busy, 1);
    tick();
    check_val("t6.idle", busy, 0);
    check_val("t6.nlaunch", n_launch - l0, 0);
    check_val("t6.nres", res_q.size() - r0, 0);

    // watchdog
    r0 = res_q.size();
    start_search(32'h00000001);
    wait_launch("t7.launch");
`ifdef ACQ_SCHED_TIMEOUT_EN
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    check_val("t7.tmo_cycles", n, 101);
    check_val("t7.timeout_err", timeout_err, 1);
    wait_idle("t7.idle");
    check_val("t7.nres", res_q.size() - r0, 1);
    check_val("t7.sticky", timeout_err, 1);
    start_search(32'h0);
    check_val("t7.cleared", timeout_err, 0);
    tick();
`else
    repeat (150) tick();
    check_val("t7.still_busy", busy, 1);
    check_val("t7.no_result", res_valid, 0);
    check_val("t7.timeout_err", timeout_err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t7.aborted", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/acq_sched.md
ACQ_SCHED -- requirements
Module: acq_sched

Interface
REQ-001 SHALL have parameter METRIC_W, default 12, meaning the correlator metric width.
REQ-002 SHALL have parameter THRESHOLD, default 12'd2400, meaning the minimum peak metric declared "found".
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd16000000, meaning the watchdog limit per group (only with ACQ_SCHED_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  system clock; one clock domain; all logic is rising-edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports start (in, 1, pulse begins a search) and abort (in, 1, pulse cancels the search).
REQ-007 SHALL have port sat_mask  in  32  bit n enables PRN n+1; sampled on the accepted start.
REQ-008 SHALL have ports core_start (out, 1, one-cycle launch pulse) and core_sat_base (out, 6, first PRN of the 4-lane group).
REQ-009 SHALL have ports core_corr_valid (in, 1, one code-phase result ready), core_code_phase (in, 10), core_doppler (in, 16 signed) and core_metric0..3 (in, METRIC_W each).
REQ-010 SHALL have port core_group_done  in  1  pulse: the core finished all phases and Dopplers for the group.
REQ-011 SHALL have ports res_valid/res_ready (out/in), res_prn (out, 6), res_code_phase (out, 10), res_doppler (out, 16 signed), res_metric (out, METRIC_W) and res_found (out, 1).
REQ-012 SHALL have ports busy (out, 1), done (out, 1-cycle pulse) and timeout_err (out, 1, sticky until next start).

Function
REQ-013 SHALL partition PRN 1..32 into 8 groups g=0..7 of 4 lanes; group g has base PRN 4g+1, and lane k is PRN 4g+1+k.
REQ-014 SHALL skip any group whose 4 sat_mask bits are all zero; a start with sat_mask==0 SHALL go IDLE->DONE->IDLE and produce no results.
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT, REPORT, NEXT and DONE.
REQ-016 IDLE->LAUNCH on start; start SHALL be ignored while busy=1.
REQ-017 LAUNCH SHALL assert core_start for exactly one cycle, with core_sat_base stable from LAUNCH until that group leaves REPORT, then go to WAIT.
REQ-018 In WAIT, on each core_corr_valid, lane k SHALL latch metric, code phase and Doppler only if core_metric_k > stored peak (strictly greater; the first equal peak is kept); the stored peak is cleared to 0 in LAUNCH.
REQ-019 WAIT->REPORT on core_group_done; a core_corr_valid in the same cycle SHALL be included before reporting.
REQ-020 REPORT SHALL emit one result per enabled lane in ascending PRN order; a result transfers when res_valid&&res_ready.
REQ-021 While res_valid=1 and res_ready=0, the res_* fields SHALL hold stable.
REQ-022 res_found SHALL equal (res_metric >= THRESHOLD).
REQ-023 Disabled lanes SHALL emit nothing.
REQ-024 After the last transfer, REPORT->NEXT; NEXT SHALL pick the next enabled group (LAUNCH) or, if none remain, go to DONE.
REQ-025 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-026 core_corr_valid and core_group_done SHALL be ignored outside WAIT.
REQ-027 abort in any non-IDLE state SHALL go to IDLE next cycle, drop res_valid with no further transfers, and not pulse done; abort wins over a simultaneous start or group_done.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 On rst=1: state=IDLE and busy, done, core_start, res_valid, timeout_err=0; core_sat_base=6'd1; all peaks, res_* fields and the group index=0.
REQ-030 A reset asserted mid-search SHALL abandon the search with no done pulse; the core is not notified.

Configuration
REQ-031 With ACQ_SCHED_TIMEOUT_EN defined, a counter SHALL start in LAUNCH; if it reaches TIMEOUT_CYCLES in WAIT, the block SHALL set timeout_err and go to REPORT with the current peaks.
REQ-032 Without ACQ_SCHED_TIMEOUT_EN, the counter is absent, timeout_err is tied to 0, and WAIT waits indefinitely.

Structure
REQ-033 acq_sched_pkg SHALL hold the state enum, LANES=4, GROUPS=8 and the base-PRN function (4g+1).
REQ-034 SHALL instantiate 4 copies of sub-module acq_peak_tracker (per-lane compare/latch of metric, phase and Doppler; clear input).

Verification
REQ-035 sat_mask=32'h0000000F, core lane2 peak 3000 at phase 517, Doppler 26 -> one LAUNCH with base 1; 4 results PRN 1..4, PRN3 found=1 with phase 517, Doppler 26.
REQ-036 sat_mask=32'h80000001 -> launches with base 1 then 29; results for PRN1 and PRN32 only; one done pulse.
REQ-037 Equal metrics 2500 at phases 10 and 20 -> reported phase 10; metric 2399 -> found=0.
REQ-038 res_ready held low 50 cycles during REPORT -> res_* stable; no lost or duplicated result.
REQ-039 abort during WAIT plus simultaneous group_done -> IDLE next cycle, no results, no done; start of a new search with the same mask succeeds.
REQ-040 With ACQ_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100 and no group_done -> REPORT after 100 cycles, timeout_err=1; the next start clears it.
